// File: rtl/priority_encoder_arb_pkg.sv
// Shared types and constants for the registered priority encoder / arbiter.
// Holds the mode encodings, the FSM state type and a constant-width helper.
package prio_enc_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/priority_encoder_n.sv
// Combinational N-input priority encoder: the highest set index wins.
// gs flags that at least one input is set; enc is 0 when none is.
module priority_encoder_n
  import prio_enc_pkg::*;
#(
  parameter  int N = 32,
  localparam int W = clog2(N)
) (
  input  logic [N-1:0] dec,
  output logic [W-1:0] enc,
  output logic         gs
);

  // Ascending scan so the last (highest) set bit overwrites earlier hits.
  always_comb begin
    enc = '0;
    gs  = 1'b0;
    for (int i = 0; i < N; i++) begin
      enc = dec[i] ? W'(i) : enc;
      gs  = gs | dec[i];
    end
  end

endmodule

// File: rtl/priority_encoder_arb.sv
// Registered request funnel: pending latch, enable mask, fixed-priority or
// round-robin winner selection, presented on a valid/ready output.
module priority_encoder_arb
  import prio_enc_pkg::*;
#(
  parameter  int N = 32,
  localparam int W = clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] mask_i,
  input  logic [N-1:0] clr_i,
  input  logic         rr_mode_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_idx_o,
  output logic [N-1:0] pending_o,
  output logic         any_o
);

  state_e         state_q;
  logic [N-1:0]   pending_q;
  logic [N-1:0]   pending_d;
  logic           out_valid_q;
  logic [W-1:0]   out_idx_q;
  logic [W-1:0]   ptr_q;
  logic           mode_q;

  logic [N-1:0]   cand_s;
  logic [N-1:0]   below_s;
  logic [N-1:0]   acc_s;
  logic [W-1:0]   enc_lo_s;
  logic [W-1:0]   enc_all_s;
  logic [W-1:0]   win_s;
  logic           gs_lo_s;
  logic           gs_all_s;

  assign cand_s = pending_q & mask_i;

  // Channels strictly below the round-robin pointer.
  always_comb begin
    below_s = '0;
    for (int i = 0; i < N; i++) begin
      below_s[i] = (i < int'(ptr_q));
    end
  end

  // One-hot of the index being accepted this cycle.
  always_comb begin
    if (out_valid_q && out_ready_i) begin
      acc_s = {{(N-1){1'b0}}, 1'b1} << out_idx_q;
    end else begin
      acc_s = '0;
    end
  end

  // A fresh request survives its own accept; a clear beats everything.
  assign pending_d = ((pending_q & ~acc_s) | req_i) & ~clr_i;

  priority_encoder_n #(.N(N)) u_enc_lo (
    .dec (cand_s & below_s),
    .enc (enc_lo_s),
    .gs  (gs_lo_s)
  );

  priority_encoder_n #(.N(N)) u_enc_all (
    .dec (cand_s),
    .enc (enc_all_s),
    .gs  (gs_all_s)
  );

  // Round-robin falls back to the overall winner when nothing sits below ptr.
  always_comb begin
    if ((rr_mode_i == MODE_RR) && gs_lo_s) begin
      win_s = enc_lo_s;
    end else begin
      win_s = enc_all_s;
    end
  end

  // Pending register plus the grant FSM with its registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      ptr_q       <= '0;
      mode_q      <= MODE_FIXED;
    end else begin
      pending_q <= pending_d;
      case (state_q)
        IDLE: begin
          if (gs_all_s) begin
            out_idx_q   <= win_s;
            out_valid_q <= 1'b1;
            mode_q      <= rr_mode_i;
            state_q     <= PRESENT;
          end else begin
            out_valid_q <= 1'b0;
          end
        end
        PRESENT: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
            if (mode_q == MODE_RR) begin
              ptr_q <= out_idx_q;
            end
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_idx_o   = out_idx_q;
  assign pending_o   = pending_q;
  assign any_o       = |cand_s;

endmodule
